// File: rtl/lca_mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams NBYTES-wide operands through
// one shared 8-bit look-ahead-carry slice, LSB byte first, with a chained carry.

module lca_dataflow (
  output logic [7:0] sum,
  output logic       cout,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin
);
  logic [7:0] g, p;
  logic [8:0] c;

  // Each carry is a flat sum of generate terms, not a ripple of the previous carry.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      logic cc;
      logic prop;
      cc   = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cc   = cc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = cc | (prop & cin);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one byte through the slice per cycle, LSB first
// DONE  | result and flags held, out_valid=1 until out_ready
module lca_mp_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES) + 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_reg, b_reg;
  logic          carry;
  logic [IW-1:0] idx;
  logic [7:0]    s_a, s_b, s_sum;
  logic          s_cout;

  assign s_a = a_reg[{idx, 3'b000} +: 8];
  assign s_b = b_reg[{idx, 3'b000} +: 8];

  lca_dataflow u_slice (
    .sum  (s_sum),
    .cout (s_cout),
    .a    (s_a),
    .b    (s_b),
    .cin  (carry)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= op_a;
            // Subtract is A + ~B + 1; the +1 enters through the initial carry.
            b_reg  <= sub ? ~op_b : op_b;
            carry  <= sub;
            idx    <= '0;
            result <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          result[{idx, 3'b000} +: 8] <= s_sum;
          carry <= s_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            carry_out <= s_cout;
            overflow  <= (a_reg[W-1] == b_reg[W-1]) && (s_sum[7] != a_reg[W-1]);
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lca_mp_add_seq.sv
// Directed and random checks of lca_mp_add_seq (NBYTES=4) against an
// arithmetic reference model.

module tb_lca_mp_add_seq;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a, op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  lca_mp_add_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic on the full-width operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic v);
    longint unsigned ua, ub;
    longint sa, sb, sres;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!s) begin
      r    = a + b;
      c    = (ua + ub) > 64'hFFFF_FFFF;
      sres = sa + sb;
    end else begin
      r    = a - b;
      c    = (ua >= ub);
      sres = sa - sb;
    end
    v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    check("accept_ready", 64'(in_ready), 64'd1);
    op_a = a;
    op_b = b;
    sub = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    sub = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      op_a = $urandom;
      op_b = $urandom;
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
    logic [W-1:0] r;
    logic c, v;
    model(a, b, s, r, c, v);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(result), 64'(r));
    check({tag, "_carry"}, 64'(carry_out), 64'(c));
    check({tag, "_ovf"}, 64'(overflow), 64'(v));
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_in_ready", 64'(in_ready), 64'd1);
    check("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic run_full(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
    int lat;
    start_op(a, b, s);
    wait_done(lat);
    check({tag, "_latency"}, 64'(lat), 64'(NBYTES));
    check_res(tag, a, b, s);
    drain();
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb, rr;
    logic rs, rc, rv;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_carry", 64'(carry_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic cases; expected values also spelled out explicitly.
    run_full("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0);
    check("add_ff_1_const", 64'(result), 64'h0000_0100);
    run_full("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("add_wrap_const", 64'({result, carry_out, overflow}), 64'({32'h0, 1'b1, 1'b0}));
    run_full("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check("add_ovf_const", 64'({result, carry_out, overflow}), 64'({32'h8000_0000, 1'b0, 1'b1}));
    run_full("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1);
    check("sub_ovf_const", 64'({result, carry_out, overflow}), 64'({32'h7FFF_FFFF, 1'b1, 1'b1}));
    run_full("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1);
    check("sub_borrow_const", 64'({result, carry_out, overflow}), 64'({32'hFFFF_FFFE, 1'b0, 1'b0}));
    run_full("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1);
    check("sub_equal_const", 64'({result, carry_out, overflow}), 64'({32'h0, 1'b1, 1'b0}));

    // Backpressure: hold DONE for 10 cycles with a stray in_valid pulse.
    start_op(32'hA5A5_1234, 32'h5A5A_4321, 1'b0);
    wait_done(lat);
    check("bp_latency", 64'(lat), 64'(NBYTES));
    model(32'hA5A5_1234, 32'h5A5A_4321, 1'b0, rr, rc, rv);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) begin
        op_a = 32'h1111_1111;
        op_b = 32'h2222_2222;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_result", 64'(result), 64'(rr));
      check("bp_flags", 64'({carry_out, overflow}), 64'({rc, rv}));
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_queue", 64'({in_ready, out_valid}), 64'b10);
    check("bp_hold_after_drain", 64'(result), 64'(rr));

    // in_valid together with out_ready in DONE: drain first, accept next cycle.
    start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
    wait_done(lat);
    check_res("ov_first", 32'h0000_0010, 32'h0000_0020, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'h0BAD_F00D;
    sub = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ov_drain_idle", 64'({in_ready, out_valid}), 64'b10);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ov_accept", 64'(in_ready), 64'd0);
    wait_done(lat);
    check("ov_latency", 64'(lat), 64'(NBYTES));
    check_res("ov_second", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    drain();

    // Reset during the second RUN cycle discards the operation.
    start_op(32'hCAFE_F00D, 32'h1234_4321, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    run_full("post_rst", 32'h0000_0001, 32'h0000_0001, 1'b0);
    check("post_rst_const", 64'(result), 64'h0000_0002);

    // Random operations with random consumer stalls.
    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
      rs = 1'($urandom);
      start_op(ra, rb, rs);
      wait_done(lat);
      check("rnd_latency", 64'(lat), 64'(NBYTES));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      check_res("rnd", ra, rb, rs);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
